// File: rtl/bus_cycle_ctrl.sv
// Bus-cycle sequencer feeding io_buffer.
// Turns fetch, read and queued write requests into T1/T2/T3 machine cycles.
// Writes drain from a small FIFO before any read or fetch may start, so a
// read always observes every earlier write.
module bus_cycle_ctrl #(
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_req,
    input  logic          rd_req,
    input  logic [AW-1:0] req_addr,
    output logic          req_ready,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic [DW-1:0] mdat_in,
    output logic [DW-1:0] rdata,
    output logic          rdata_valid,
    output logic [AW-1:0] addr,
    output logic          mrd,
    output logic          fetch,
    output logic          clk2,
    output logic [DW-1:0] alout,
    output logic          busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
    typedef enum logic [1:0] {CYC_WR, CYC_RD, CYC_FETCH} cyc_t;

    state_t        state;
    state_t        state_nx;
    cyc_t          cyc;
    cyc_t          cyc_nx;

    logic [AW-1:0] fifo_addr [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] head_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_left;

    logic          issue_pt;
    logic          push;
    logic          pop;
    logic          rd_path_free;

    assign issue_pt   = (state == IDLE) || (state == T3);
    assign pop        = (state == T3) && (cyc == CYC_WR);
    assign count_left = count - CW'(pop);
    assign wr_ready   = (count != CW'(DEPTH));
    assign push       = wr_req && wr_ready;

    // When a write is popped on the same edge that the next write starts,
    // the new head is one slot past the current read pointer.
    assign head_ptr   = pop ? (rd_ptr + PW'(1)) : rd_ptr;

    assign rd_path_free = issue_pt && (count_left == '0) && !wr_req;
    assign req_ready    = rd_path_free && (fetch_req || rd_req);

    assign busy = (state != IDLE) || (count != '0);

    // Next machine phase and cycle type; issue decisions made in IDLE and T3
    always_comb begin
        state_nx = state;
        cyc_nx   = cyc;
        case (state)
            IDLE, T3: begin
                state_nx = IDLE;
                if (count_left != '0) begin
                    state_nx = T1;
                    cyc_nx   = CYC_WR;
                end else if (rd_path_free && fetch_req) begin
                    state_nx = T1;
                    cyc_nx   = CYC_FETCH;
                end else if (rd_path_free && rd_req) begin
                    state_nx = T1;
                    cyc_nx   = CYC_RD;
                end
            end
            T1:      state_nx = T2;
            T2:      state_nx = T3;
            default: state_nx = IDLE;
        endcase
    end

    // Phase register with bus outputs decoded from the next phase
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cyc         <= CYC_WR;
            addr        <= '0;
            alout       <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            mrd         <= 1'b0;
            fetch       <= 1'b0;
            clk2        <= 1'b1;
        end else begin
            state       <= state_nx;
            cyc         <= cyc_nx;
            clk2        <= (state_nx != T2);
            mrd         <= (state_nx == T2) && (cyc_nx == CYC_RD);
            fetch       <= (state_nx == T2) && (cyc_nx == CYC_FETCH);
            rdata_valid <= (state == T2) && (cyc != CYC_WR);
            if ((state == T2) && (cyc != CYC_WR)) begin
                rdata <= mdat_in;
            end
            if (state_nx == T1) begin
                if (cyc_nx == CYC_WR) begin
                    addr  <= fifo_addr[head_ptr];
                    alout <= fifo_data[head_ptr];
                end else begin
                    addr  <= req_addr;
                end
            end
        end
    end

    // Write FIFO storage; contents need no reset since count guards them
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

    // Write FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl with a write/read scoreboard and a
// small external memory model answering reads on mdat_in.
module tb_bus_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic        rd_req;
    logic [15:0] req_addr;
    logic        req_ready;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic [7:0]  mdat_in;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic [15:0] addr;
    logic        mrd;
    logic        fetch;
    logic        clk2;
    logic [7:0]  alout;
    logic        busy;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        f;
    } rd_t;

    wr_t wq[$];
    rd_t rq[$];
    logic [7:0] bmem [logic [15:0]];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_cycle_ctrl #(.DW(8), .AW(16), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .rd_req      (rd_req),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .mdat_in     (mdat_in),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .addr        (addr),
        .mrd         (mrd),
        .fetch       (fetch),
        .clk2        (clk2),
        .alout       (alout),
        .busy        (busy)
    );

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus monitor and memory model, sampled mid-cycle
    always @(negedge clk) begin
        wr_t w;
        rd_t r;
        if (clk2 === 1'b0 && mrd === 1'b0 && fetch === 1'b0) begin
            bmem[addr] = alout;
            if (wq.size() > 0) begin
                w = wq.pop_front();
                chk("wr_addr", 32'(addr), 32'(w.a));
                chk("wr_data", 32'(alout), 32'(w.d));
            end else begin
                chk("wr_unexpected", 32'(1), 32'(0));
            end
        end
        if (clk2 === 1'b0 && (mrd === 1'b1 || fetch === 1'b1)) begin
            if (rq.size() > 0) begin
                chk("rd_addr", 32'(addr), 32'(rq[0].a));
                chk("rd_fetch", 32'(fetch), 32'(rq[0].f));
                chk("rd_mrd", 32'(mrd), 32'(!rq[0].f));
            end else begin
                chk("rd_unexpected", 32'(1), 32'(0));
            end
        end
        if (mrd === 1'b1 || fetch === 1'b1) begin
            chk("strobe_clk2", 32'(clk2), 32'(0));
        end
        if (rdata_valid === 1'b1) begin
            if (rq.size() > 0) begin
                r = rq.pop_front();
                chk("rdata", 32'(rdata), 32'(r.d));
            end else begin
                chk("rdata_unexpected", 32'(1), 32'(0));
            end
        end
        mdat_in = bmem.exists(addr) ? bmem[addr] : dflt(addr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] exp_rdy;
        int wi;
        int waited;

        bmem[16'h1234] = 8'hA5;
        rst_n = 1'b0; fetch_req = 1'b0; rd_req = 1'b0; req_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset
        tick(); tick();
        chk("rst_clk2", 32'(clk2), 32'(1));
        chk("rst_mrd", 32'(mrd), 32'(0));
        chk("rst_fetch", 32'(fetch), 32'(0));
        chk("rst_alout", 32'(alout), 32'(0));
        chk("rst_addr", 32'(addr), 32'(0));
        chk("rst_rvalid", 32'(rdata_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_wr_ready", 32'(wr_ready), 32'(1));
        rst_n = 1'b1;
        tick();

        // Single read
        rd_req = 1'b1; req_addr = 16'h1234;
        #1;
        chk("rd_req_ready", 32'(req_ready), 32'(1));
        rq.push_back('{a: 16'h1234, d: 8'hA5, f: 1'b0});
        tick();
        rd_req = 1'b0;
        chk("rd_t1_addr", 32'(addr), 32'h1234);
        chk("rd_t1_clk2", 32'(clk2), 32'(1));
        chk("rd_t1_mrd", 32'(mrd), 32'(0));
        #1;
        chk("rd_t1_req_ready", 32'(req_ready), 32'(0));
        tick();
        chk("rd_t2_addr", 32'(addr), 32'h1234);
        chk("rd_t2_clk2", 32'(clk2), 32'(0));
        chk("rd_t2_mrd", 32'(mrd), 32'(1));
        chk("rd_t2_rvalid", 32'(rdata_valid), 32'(0));
        tick();
        chk("rd_t3_addr", 32'(addr), 32'h1234);
        chk("rd_t3_mrd", 32'(mrd), 32'(0));
        chk("rd_t3_rvalid", 32'(rdata_valid), 32'(1));
        chk("rd_t3_rdata", 32'(rdata), 32'hA5);
        tick();
        chk("rd_idle_rvalid", 32'(rdata_valid), 32'(0));
        chk("rd_idle_busy", 32'(busy), 32'(0));

        // Write burst: six writes, FIFO fills and retries
        exp_rdy = 9'b1_0010_1111; // bit c = expected wr_ready in request cycle c
        wi = 0;
        for (int c = 0; c < 9; c++) begin
            wr_req  = 1'b1;
            wr_addr = 16'h0100 + 16'(wi);
            wr_data = 8'(8'h11 * (wi + 1));
            #1;
            chk("burst_wr_ready", 32'(wr_ready), 32'(exp_rdy[c]));
            if (exp_rdy[c]) begin
                wq.push_back('{a: wr_addr, d: wr_data});
                wi++;
            end
            if (c == 4) chk("burst_busy", 32'(busy), 32'(1));
            tick();
        end
        wr_req = 1'b0;
        chk("burst_count", 32'(wi), 32'(6));
        waited = 0;
        while (busy !== 1'b0 && waited < 40) begin
            tick();
            waited++;
        end
        chk("burst_drain_busy", 32'(busy), 32'(0));
        chk("burst_wq_empty", 32'(wq.size()), 32'(0));

        // Ordering: read waits for earlier write
        wr_req = 1'b1; wr_addr = 16'h0200; wr_data = 8'h5A;
        wq.push_back('{a: 16'h0200, d: 8'h5A});
        tick();
        wr_req = 1'b0;
        rd_req = 1'b1; req_addr = 16'h0200;
        rq.push_back('{a: 16'h0200, d: 8'h5A, f: 1'b0});
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("ord_req_ready", 32'(req_ready), 32'(c == 3));
            tick();
        end
        rd_req = 1'b0;
        chk("ord_t1_addr", 32'(addr), 32'h0200);
        chk("ord_t1_clk2", 32'(clk2), 32'(1));
        chk("ord_t1_busy", 32'(busy), 32'(1));
        tick(); tick(); tick();
        chk("ord_idle_busy", 32'(busy), 32'(0));

        // Priority: fetch over read, read chained after fetch
        fetch_req = 1'b1; rd_req = 1'b1; req_addr = 16'h0040;
        #1;
        chk("pri_req_ready_f", 32'(req_ready), 32'(1));
        rq.push_back('{a: 16'h0040, d: dflt(16'h0040), f: 1'b1});
        tick();
        fetch_req = 1'b0;
        #1;
        chk("pri_t1_req_ready", 32'(req_ready), 32'(0));
        tick();
        chk("pri_t2_fetch", 32'(fetch), 32'(1));
        chk("pri_t2_mrd", 32'(mrd), 32'(0));
        tick();
        #1;
        chk("pri_t3_req_ready_r", 32'(req_ready), 32'(1));
        rq.push_back('{a: 16'h0040, d: dflt(16'h0040), f: 1'b0});
        tick();
        rd_req = 1'b0;
        chk("pri_r_t1_addr", 32'(addr), 32'h0040);
        chk("pri_r_t1_busy", 32'(busy), 32'(1));
        tick();
        chk("pri_r_t2_mrd", 32'(mrd), 32'(1));
        chk("pri_r_t2_fetch", 32'(fetch), 32'(0));
        tick(); tick();
        chk("pri_rq_empty", 32'(rq.size()), 32'(0));

        // Reset during T2 of a write with three entries queued
        for (int c = 0; c < 3; c++) begin
            wr_req = 1'b1; wr_addr = 16'h0400 + 16'(c); wr_data = 8'hC1 + 8'(c);
            wq.push_back('{a: wr_addr, d: wr_data});
            tick();
        end
        wr_req = 1'b0;
        chk("mid_t2_clk2", 32'(clk2), 32'(0));
        chk("mid_t2_alout", 32'(alout), 32'hC1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_clk2", 32'(clk2), 32'(1));
        chk("mid_rst_wr_ready", 32'(wr_ready), 32'(1));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_alout", 32'(alout), 32'(0));
        chk("mid_rst_addr", 32'(addr), 32'(0));
        chk("mid_wq_left", 32'(wq.size()), 32'(2));
        wq.delete();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        chk("mid_after_busy", 32'(busy), 32'(0));

        // Reset during T2 of a read: no data delivered
        rd_req = 1'b1; req_addr = 16'h0300;
        #1;
        chk("rrst_req_ready", 32'(req_ready), 32'(1));
        rq.push_back('{a: 16'h0300, d: dflt(16'h0300), f: 1'b0});
        tick();
        rd_req = 1'b0;
        tick();
        chk("rrst_t2_mrd", 32'(mrd), 32'(1));
        rst_n = 1'b0;
        tick();
        chk("rrst_rvalid", 32'(rdata_valid), 32'(0));
        chk("rrst_mrd", 32'(mrd), 32'(0));
        chk("rrst_clk2", 32'(clk2), 32'(1));
        chk("rrst_rq_left", 32'(rq.size()), 32'(1));
        rq.delete();
        rst_n = 1'b1;
        tick();
        chk("rrst_after_rvalid", 32'(rdata_valid), 32'(0));
        tick(); tick();

        chk("final_wq_empty", 32'(wq.size()), 32'(0));
        chk("final_rq_empty", 32'(rq.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
Bus-cycle sequencer that sits directly upstream of io_buffer and drives its mrd, fetch and clk2 strobes and its alout data. It turns core fetch, read and write requests into three-phase machine cycles (T1/T2/T3) on the 8-bit external data bus. Writes are queued in a small FIFO and drained in order. A read or fetch is started only when the write queue is empty, so a read always observes every earlier write.

Parameters:
DW, 8, data bus width
AW, 16, address width
DEPTH, 4, write FIFO entries (power of 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
fetch_req  input  1  instruction fetch request
rd_req  input  1  data read request
req_addr  input  AW  address for fetch or read
req_ready  output  1  fetch or read accepted this cycle when its request is high
wr_req  input  1  write request
wr_addr  input  AW  write address
wr_data  input  DW  write data
wr_ready  output  1  FIFO not full; write accepted when wr_req is high
mdat_in  input  DW  external bus sampled during reads
rdata  output  DW  captured read or fetch data
rdata_valid  output  1  one-cycle pulse when rdata is updated
addr  output  AW  bus address
mrd  output  1  read strobe to io_buffer
fetch  output  1  fetch strobe to io_buffer
clk2  output  1  phase strobe to io_buffer; low only in T2
alout  output  DW  write data to io_buffer
busy  output  1  state is not IDLE, or FIFO is not empty

Behaviour:
- Reset (rst_n low at a clk edge) takes effect at that edge:
  - state = IDLE; FIFO flushed (count = 0).
  - addr = 0, alout = 0, rdata = 0, rdata_valid = 0.
  - mrd = 0, fetch = 0, clk2 = 1.
  - A reset in any phase aborts the cycle in progress. Its read data is not delivered, and queued writes are lost.
- States: IDLE, T1, T2, T3. Every machine cycle is T1 -> T2 -> T3, one clk each.
- All bus outputs are registered and decoded from the next state, so each takes its phase value in that phase's cycle.
- Phase outputs:
  - T1: clk2 = 1; addr and alout (for writes) are valid.
  - T2: clk2 = 0. Read cycle: mrd = 1. Fetch cycle: fetch = 1. Write cycle: mrd = fetch = 0, so io_buffer drives alout.
  - T3: clk2 = 1, mrd = 0, fetch = 0; addr and alout are held.
  - IDLE: clk2 = 1, strobes = 0, addr and alout are held.
- Write FIFO:
  - wr_ready = (count != DEPTH), combinational from registered count, in any state.
  - A push happens when wr_req and wr_ready are both high.
  - A pop happens at the T3 -> next edge of a write cycle.
  - When full, a push in the same cycle as a pop is still rejected (wr_ready low); count changes by at most ±1.
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Issue rules, evaluated in IDLE and in T3 (T3 may chain directly to T1):
  1. FIFO non-empty, after any pop due this edge: start a write cycle. addr and alout take the FIFO head at entry to T1.
  2. Otherwise, if fetch_req: start a fetch.
  3. Otherwise, if rd_req: start a read.
- req_ready is high only when all of these hold: an issue point, FIFO empty after the pending pop, wr_req low, fetch/rd would be chosen. Fetch has priority over read. When a fetch and read are both requested, req_ready acknowledges the fetch only; the read stays pending.
- Reads and fetches:
  - mdat_in is captured into rdata at the T2 -> T3 edge.
  - rdata_valid = 1 during T3 only.
  - Latency: accept edge k gives T1 at k+1, T2 at k+2, rdata_valid at k+3.
- A write pushed while a read is in flight starts no earlier than the T3 after that read.
- busy = (state != IDLE) | (count != 0).

Test Plan:
- Reset: hold rst_n = 0 for 2 clks, then release -> clk2 = 1, mrd = fetch = 0, alout = 0, addr = 0, rdata_valid = 0, busy = 0, wr_ready = 1.
- Single read: rd_req with req_addr = 0x1234, mdat_in = 0xA5 -> req_ready for 1 cycle; addr = 0x1234 for 3 cycles; mrd = 1 only in cycle +2, with clk2 = 0 that cycle; rdata = 0xA5 and rdata_valid = 1 in cycle +3 only.
- Write burst: wr_req for 6 consecutive cycles, data 0x11..0x66, addr 0x0100..0x0105 -> first four accepted; wr_ready low in the 5th request cycle (count = 4) and the 5th is retried and accepted next cycle; alout sequence on T2 is 0x11, 0x22, … in order, each with clk2 = mrd = fetch = 0; busy drops one cycle after the last T3.
- Ordering: write 0x5A to 0x0200, then rd_req to 0x0200 on the next cycle -> req_ready stays low until the write's T3; the read's T1 immediately follows that write's T3.
- Priority: fetch_req and rd_req high together in IDLE, addr 0x0040 -> fetch = 1 in T2 with mrd = 0; the read is served in the next machine cycle (T3 -> T1 back-to-back).
- Reset mid-cycle: assert rst_n = 0 during T2 of a write with 3 entries queued -> next cycle clk2 = 1, count = 0, wr_ready = 1, no further write strobes; no rdata_valid on reset of an in-flight read.
